display_scanner: RTL and testbench

Parametrised successor to the timer's fixed 4-digit ring-counter display selector. It drives multiplexed 7-segment displays of the irrigation timer. The block cycles a one-hot digit enable across `DIGITS` displays with a programmable dwell time and an anti-ghosting blank interval. It skips masked digits and routes the selected digit's code onto a shared segment bus. It also flags each completed frame so the timer can refresh its display digits coherently.

---
 rtl/display_pkg.sv | 20 ++
 rtl/digit_mask_search.sv | 38 +++
 rtl/display_scanner.sv | 145 ++++++++++++++
 tb/tb_display_scanner.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display scanner.
package display_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShow  = 2'd1,
        StBlank = 2'd2
    } scan_state_t;

    // Widest digit vector the polarity helper handles; callers truncate to their width.
    localparam int unsigned MaxDigits = 32;

    function automatic logic [MaxDigits-1:0] apply_polarity(
        input logic [MaxDigits-1:0] onehot,
        input logic                 active_low
    );
        return active_low ? ~onehot : onehot;
    endfunction

endpackage

// File: rtl/digit_mask_search.sv
// Combinational descending search with wrap for the next enabled digit.
module digit_mask_search #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned IdxW   = 2
) (
    input  logic [IdxW-1:0]   start_i,
    input  logic [DIGITS-1:0] mask_i,
    input  logic              inclusive_i,
    output logic [IdxW-1:0]   next_o,
    output logic              found_o,
    output logic              wrapped_o
);

    int unsigned     off;
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        next_o    = start_i;
        found_o   = 1'b0;
        off       = 0;
        cand      = 0;
        cand_idx  = '0;
        // Exclusive searches visit start_i last, so a lone enabled digit finds itself.
        for (int unsigned k = 0; k < DIGITS; k++) begin
            off      = inclusive_i ? k : k + 1;
            cand     = (32'(start_i) >= off) ? 32'(start_i) - off
                                             : 32'(start_i) + DIGITS - off;
            cand_idx = cand[IdxW-1:0];
            if (!found_o && mask_i[cand_idx]) begin
                found_o = 1'b1;
                next_o  = cand_idx;
            end
        end
        wrapped_o = found_o && (inclusive_i ? (next_o > start_i) : (next_o >= start_i));
    end

endmodule

// File: rtl/display_scanner.sv
// Scans a one-hot digit enable across DIGITS displays with dwell, blanking and masking,
// muxing the selected digit code onto a shared segment bus.
module display_scanner
    import display_pkg::*;
#(
    parameter int unsigned  DIGITS     = 4,
    parameter int unsigned  DATA_W     = 4,
    parameter int unsigned  DWELL      = 1000,
    parameter int unsigned  BLANK      = 16,
    parameter bit           ACTIVE_LOW = 1'b0,
    localparam int unsigned IdxW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic [DIGITS-1:0]        digit_mask_i,
    input  logic [DIGITS*DATA_W-1:0] digit_data_i,
    output logic [DIGITS-1:0]        displays_o,
    output logic [DATA_W-1:0]        segment_data_o,
    output logic [IdxW-1:0]          index_o,
    output logic                     frame_done_o
);

    localparam int unsigned     CntMax    = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned     CntW      = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'((BLANK > 0) ? BLANK - 1 : 0);

    scan_state_t       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              hunt_q, hunt_d;
    logic [IdxW-1:0]   index_q, index_d;
    logic [DIGITS-1:0] displays_q, displays_d;
    logic [DATA_W-1:0] segment_q, segment_d;
    logic              frame_q, frame_d;
    logic [DIGITS-1:0] onehot;

    logic [IdxW-1:0] search_next;
    logic            search_found;
    logic            search_wrapped;

    // Inclusive only when (re)starting from IDLE; every advance looks strictly below.
    digit_mask_search #(
        .DIGITS (DIGITS),
        .IdxW   (IdxW)
    ) u_search (
        .start_i     (index_q),
        .mask_i      (digit_mask_i),
        .inclusive_i (state_q == StIdle),
        .next_o      (search_next),
        .found_o     (search_found),
        .wrapped_o   (search_wrapped)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hunt_q     <= 1'b0;
            index_q    <= IdxW'(DIGITS - 1);
            displays_q <= DIGITS'(apply_polarity('0, ACTIVE_LOW));
            segment_q  <= '0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hunt_q     <= hunt_d;
            index_q    <= index_d;
            displays_q <= displays_d;
            segment_q  <= segment_d;
            frame_q    <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        hunt_d  = hunt_q;
        index_d = index_q;
        frame_d = 1'b0;
        if (!enable_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            hunt_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (search_found) begin
                        state_d = StShow;
                        index_d = search_next;
                    end
                end
                StShow: begin
                    if (cnt_q == DwellLast) begin
                        cnt_d = '0;
                        if (search_found) begin
                            index_d = search_next;
                            frame_d = search_wrapped;
                            state_d = (BLANK == 0) ? StShow : StBlank;
                        end else begin
                            state_d = StBlank;
                            hunt_d  = 1'b1;
                        end
                    end
                end
                StBlank: begin
                    if (hunt_q) begin
                        // Nothing enabled: stay dark and retry the search every cycle.
                        cnt_d = '0;
                        if (search_found) begin
                            index_d = search_next;
                            frame_d = search_wrapped;
                            state_d = StShow;
                            hunt_d  = 1'b0;
                        end
                    end else if (cnt_q == BlankLast) begin
                        cnt_d   = '0;
                        state_d = StShow;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    hunt_d  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        onehot = '0;
        if (state_d == StShow) begin
            onehot[index_d] = 1'b1;
        end
        displays_d = DIGITS'(apply_polarity(MaxDigits'(onehot), ACTIVE_LOW));
        segment_d  = digit_data_i[index_q * DATA_W +: DATA_W];
    end

    assign displays_o     = displays_q;
    assign segment_data_o = segment_q;
    assign index_o        = index_q;
    assign frame_done_o   = frame_q;

endmodule

// File: tb/tb_display_scanner.sv
// Randomised check of display_scanner against a countdown-based reference model,
// plus literal sequences for scan, masking, blanking, enable/reset and data path.
module tb_display_scanner;

    localparam int DWELL   = 3;
    localparam int BLANK_A = 1;
    localparam int BLANK_Z = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  mask;
    logic [15:0] data;

    logic [3:0] disp_a, seg_a, disp_z, seg_z;
    logic [1:0] idx_a, idx_z;
    logic       frm_a, frm_z;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // Reference state per instance: 0 = BLANK 1 / active-high, 1 = BLANK 0 / active-low.
    bit         m_run [2];
    bit         m_lit [2];
    bit         m_hunt[2];
    bit         m_frame[2];
    int         m_idx [2];
    int         m_left[2];
    logic [3:0] m_seg [2];

    always #5 clk = ~clk;

    display_scanner #(
        .DIGITS (4), .DATA_W (4), .DWELL (DWELL), .BLANK (BLANK_A), .ACTIVE_LOW (1'b0)
    ) u_dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .enable_i       (en),
        .digit_mask_i   (mask),
        .digit_data_i   (data),
        .displays_o     (disp_a),
        .segment_data_o (seg_a),
        .index_o        (idx_a),
        .frame_done_o   (frm_a)
    );

    display_scanner #(
        .DIGITS (4), .DATA_W (4), .DWELL (DWELL), .BLANK (BLANK_Z), .ACTIVE_LOW (1'b1)
    ) u_dut_z (
        .clock_i        (clk),
        .reset_i        (rst),
        .enable_i       (en),
        .digit_mask_i   (mask),
        .digit_data_i   (data),
        .displays_o     (disp_z),
        .segment_data_o (seg_z),
        .index_o        (idx_z),
        .frame_done_o   (frm_z)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Next enabled digit going downward modulo 4; exclusive search tries start last.
    function automatic void search(input int start, input logic [3:0] m, input bit incl,
                                   output bit found, output int nxt);
        int c;
        found = 1'b0;
        nxt   = start;
        for (int s = 0; s < 4; s++) begin
            c = (((start - s - (incl ? 0 : 1)) % 4) + 4) % 4;
            if (!found && m[c]) begin
                found = 1'b1;
                nxt   = c;
            end
        end
    endfunction

    function automatic void model_step(input int k);
        bit         f;
        int         n;
        int         blank_len;
        logic [3:0] seg_new;
        blank_len  = (k == 0) ? BLANK_A : BLANK_Z;
        seg_new    = data[m_idx[k]*4 +: 4];
        m_frame[k] = 1'b0;
        if (rst) begin
            m_run[k] = 1'b0; m_lit[k] = 1'b0; m_hunt[k] = 1'b0;
            m_idx[k] = 3;    m_left[k] = 0;   m_seg[k] = 4'd0;
            return;
        end
        m_seg[k] = seg_new;
        if (!en) begin
            m_run[k] = 1'b0; m_lit[k] = 1'b0; m_hunt[k] = 1'b0;
            return;
        end
        if (!m_run[k]) begin
            search(m_idx[k], mask, 1'b1, f, n);
            if (f) begin
                m_run[k] = 1'b1; m_lit[k] = 1'b1; m_left[k] = DWELL; m_idx[k] = n;
            end
        end else if (m_lit[k]) begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin
                search(m_idx[k], mask, 1'b0, f, n);
                if (f) begin
                    m_frame[k] = (n >= m_idx[k]);
                    m_idx[k]   = n;
                    if (blank_len > 0) begin
                        m_lit[k]  = 1'b0;
                        m_left[k] = blank_len;
                    end else begin
                        m_left[k] = DWELL;
                    end
                end else begin
                    m_lit[k]  = 1'b0;
                    m_hunt[k] = 1'b1;
                end
            end
        end else if (m_hunt[k]) begin
            search(m_idx[k], mask, 1'b0, f, n);
            if (f) begin
                m_frame[k] = (n >= m_idx[k]);
                m_idx[k]   = n;
                m_lit[k]   = 1'b1;
                m_left[k]  = DWELL;
                m_hunt[k]  = 1'b0;
            end
        end else begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin
                m_lit[k]  = 1'b1;
                m_left[k] = DWELL;
            end
        end
    endfunction

    function automatic logic [3:0] exp_disp(input int k);
        logic [3:0] v;
        v = (m_run[k] && m_lit[k]) ? (4'b0001 << m_idx[k]) : 4'b0000;
        return (k == 1) ? ~v : v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("disp_a", disp_a, exp_disp(0));
            check("seg_a", seg_a, m_seg[0]);
            check("idx_a", idx_a, m_idx[0]);
            check("frame_a", frm_a, m_frame[0]);
            check("disp_z", disp_z, exp_disp(1));
            check("seg_z", seg_z, m_seg[1]);
            check("idx_z", idx_z, m_idx[1]);
            check("frame_z", frm_z, m_frame[1]);
            check("onehot_a", $countones(disp_a) <= 1, 1);
            check("onehot_z", $countones(~disp_z) <= 1, 1);
        end
    end

    logic [3:0] scan_seq [17] = '{4'h8, 4'h8, 4'h8, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h2,
                                   4'h2, 4'h2, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h8};
    logic [3:0] zb_seq [6]    = '{4'h7, 4'h7, 4'h7, 4'hB, 4'hB, 4'hB};
    logic [3:0] mask_seq [16] = '{4'h8, 4'h8, 4'h8, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                                  4'h8, 4'h8, 4'h8, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0};

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        mask = 4'hF;
        data = 16'h3527;
        cycle();
        chk_on = 1'b1;
        cycle();
        check("reset_disp_a", disp_a, 4'h0);
        check("reset_disp_z", disp_z, 4'hF);
        check("reset_seg", seg_a, 4'h0);
        check("reset_idx", idx_a, 2'd3);
        check("reset_frame", frm_a, 1'b0);

        // Basic scan, plus zero-blank active-low instance alongside.
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cycle();
            check("scan_disp", disp_a, scan_seq[i]);
            check("scan_frame", frm_a, i == 15);
            if (i < 6) check("zero_blank_disp", disp_z, zb_seq[i]);
        end

        // Data path: digit 2 code changes from 5 to 9 while selected.
        for (int j = 0; j < 12; j++) begin
            if (idx_a == 2'd2) break;
            cycle();
        end
        check("datapath_reach_idx2", idx_a, 2'd2);
        cycle();
        check("datapath_seg_old", seg_a, 4'd5);
        data[11:8] = 4'd9;
        cycle();
        check("datapath_seg_new", seg_a, 4'd9);

        // Masking, with digit 1 dropped mid-dwell.
        rst = 1'b1;
        cycle();
        rst  = 1'b0;
        mask = 4'b1010;
        for (int i = 0; i < 16; i++) begin
            cycle();
            check("mask_disp", disp_a, mask_seq[i]);
            check("mask_frame", frm_a, (i == 7) || (i == 11) || (i == 15));
            if (i == 5) mask = 4'b1000;
        end

        // All masked during digit 2's dwell.
        rst = 1'b1;
        cycle();
        rst  = 1'b0;
        mask = 4'hF;
        for (int i = 0; i < 5; i++) cycle();
        check("allmask_start", disp_a, 4'h4);
        mask = 4'h0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("allmask_finish_dwell", disp_a, 4'h4);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("allmask_dark", disp_a, 4'h0);
        end
        mask = 4'b0001;
        cycle();
        check("allmask_resume", disp_a, 4'h1);

        // Enable drop on dwell cycle 2 of digit 1, then re-enable.
        rst = 1'b1;
        cycle();
        rst  = 1'b0;
        mask = 4'hF;
        for (int i = 0; i < 10; i++) cycle();
        check("enable_pre", disp_a, 4'h2);
        en = 1'b0;
        cycle();
        check("enable_dark", disp_a, 4'h0);
        cycle();
        cycle();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("enable_full_dwell", disp_a, 4'h2);
        end
        cycle();
        check("enable_blank", disp_a, 4'h0);

        // Reset while blanking.
        rst = 1'b1;
        cycle();
        check("midreset_disp", disp_a, 4'h0);
        check("midreset_seg", seg_a, 4'h0);
        check("midreset_idx", idx_a, 2'd3);
        check("midreset_frame", frm_a, 1'b0);
        rst = 1'b0;
        cycle();
        check("midreset_restart", disp_a, 4'h8);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) en = !en;
            if ($urandom_range(0, 29) == 0) mask = 4'($urandom);
            if ($urandom_range(0, 9) == 0) data = 16'($urandom);
            cycle();
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
